// File: rtl/demux_scheduler.sv
// Sequencing controller for the 1-to-8 demux: accepts words, picks a ready channel (round-robin or directed), strobes it.
// Latency: handshake at edge k, E/CH_VALID high after edge k+1 when the sink is ready; 1 word per 2 cycles sustained.
// Backpressure: IN_READY low while a word waits in ARB; optional DEMUX_SCHED_TIMEOUT_EN drops a word stuck TIMEOUT cycles.
module demux_scheduler #(
  parameter int DW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] IN_DATA,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [2:0]    IN_DEST,
  input  logic          MODE,
  input  logic [7:0]    CH_READY,
  output logic [2:0]    S,
  output logic          E,
  output logic [DW-1:0] I,
  output logic [7:0]    CH_VALID,
  output logic          DROP
);

  // Wait-counter limit must fit the 8-bit counter.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("demux_scheduler: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [DW-1:0] r_data;
  logic [2:0]    r_dest;
  logic          r_mode;
  logic [2:0]    r_ptr;

  logic [2:0]    r_s;
  logic          r_e;
  logic [DW-1:0] r_i;
  logic [7:0]    r_ch_valid;

  logic          w_capture;
  logic          w_grant_vld;
  logic [2:0]    w_grant_ch;
  logic [2:0]    w_cand;
  logic          w_grant;
  logic          w_timeout;

  // IDLE and SEND both accept; only ARB holds off the producer.
  assign IN_READY  = (r_state == ST_IDLE) || (r_state == ST_SEND);
  assign w_capture = IN_VALID && IN_READY;
  assign w_grant   = (r_state == ST_ARB) && w_grant_vld;

  assign S        = r_s;
  assign E        = r_e;
  assign I        = r_i;
  assign CH_VALID = r_ch_valid;

  // Grant search: directed checks the one destination; RR scans ptr+1 .. ptr+8 (ptr itself last).
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = 3'd0;
    w_cand      = 3'd0;
    if (r_mode) begin
      w_grant_vld = CH_READY[r_dest];
      w_grant_ch  = r_dest;
    end else begin
      for (int i = 1; i <= 8; i++) begin
        w_cand = r_ptr + 3'(i);
        if (!w_grant_vld && CH_READY[w_cand]) begin
          w_grant_vld = 1'b1;
          w_grant_ch  = w_cand;
        end
      end
    end
  end

`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic [7:0] r_wait;
  logic       r_drop;

  // A grant on the same edge wins over the drop.
  assign w_timeout = (r_state == ST_ARB) && !w_grant_vld && (r_wait == 8'(TIMEOUT - 1));
  assign DROP      = r_drop;

  // Wait counter: zero outside ARB so it is clear on every entry, counts ungranted ARB cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait <= 8'd0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_timeout;
      if (r_state != ST_ARB) begin
        r_wait <= 8'd0;
      end else if (!w_grant_vld) begin
        r_wait <= r_wait + 8'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign DROP      = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) w_next_state = ST_ARB;
      end
      ST_ARB: begin
        if (w_grant_vld)    w_next_state = ST_SEND;
        else if (w_timeout) w_next_state = ST_IDLE;
      end
      ST_SEND: begin
        w_next_state = w_capture ? ST_ARB : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register; reset overrides every transition.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Hold registers: word, destination and mode are frozen at capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data <= '0;
      r_dest <= 3'd0;
      r_mode <= 1'b0;
    end else if (w_capture) begin
      r_data <= IN_DATA;
      r_dest <= IN_DEST;
      r_mode <= MODE;
    end
  end

  // Demux drive: one-cycle strobe on grant, S/I hold afterwards, pointer follows every grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s        <= 3'd0;
      r_e        <= 1'b0;
      r_i        <= '0;
      r_ch_valid <= 8'd0;
      r_ptr      <= 3'd7;
    end else begin
      r_e        <= 1'b0;
      r_ch_valid <= 8'd0;
      if (w_grant) begin
        r_s        <= w_grant_ch;
        r_i        <= r_data;
        r_e        <= 1'b1;
        r_ch_valid <= 8'd1 << w_grant_ch;
        r_ptr      <= w_grant_ch;
      end
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
// Bench for demux_scheduler: directed scenarios then randomized traffic against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Model tracks "word held / not held", round-robin pointer as an integer, and a FIFO of accepted words.
module tb_demux_scheduler;

  localparam int DW      = 3;
  localparam int TIMEOUT = 15;

  logic          CLK = 1'b0;
  logic          tb_rst = 1'b1;
  logic [DW-1:0] tb_data = '0;
  logic          tb_valid = 1'b0;
  logic [2:0]    tb_dest = 3'd0;
  logic          tb_mode = 1'b0;
  logic [7:0]    tb_chrdy = 8'd0;
  logic          IN_READY;
  logic [2:0]    S;
  logic          E;
  logic [DW-1:0] I;
  logic [7:0]    CH_VALID;
  logic          DROP;

  demux_scheduler #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(tb_rst), .IN_DATA(tb_data), .IN_VALID(tb_valid), .IN_READY(IN_READY),
    .IN_DEST(tb_dest), .MODE(tb_mode), .CH_READY(tb_chrdy),
    .S(S), .E(E), .I(I), .CH_VALID(CH_VALID), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit            m_known = 0;
  bit            m_busy  = 0;
  logic [DW-1:0] m_data;
  logic          m_mode;
  int            m_dest;
  int            m_ptr;
  int            m_wait;
  logic          x_e, x_drop;
  logic [2:0]    x_s;
  logic [DW-1:0] x_i;
  logic [7:0]    x_cv;
  logic [DW-1:0] sb_q[$];

  // One clock: check ready, advance the model with the current inputs, then compare outputs.
  task automatic tick();
    int  g;
    bit  found;
    if (m_known) chk("in_ready", IN_READY, !m_busy);
    if (tb_rst) begin
      m_known = 1; m_busy = 0; m_ptr = 7; m_wait = 0;
      x_e = 0; x_s = 0; x_i = 0; x_cv = 0; x_drop = 0;
      sb_q.delete();
    end else if (m_known) begin
      x_e = 0; x_cv = 0; x_drop = 0;
      if (m_busy) begin
        found = 0; g = 0;
        if (m_mode) begin
          found = tb_chrdy[m_dest]; g = m_dest;
        end else begin
          for (int off = 1; off <= 8; off++) begin
            if (!found && tb_chrdy[(m_ptr + off) % 8]) begin
              found = 1; g = (m_ptr + off) % 8;
            end
          end
        end
        if (found) begin
          x_e = 1; x_s = 3'(g); x_i = m_data; x_cv = 8'd1 << g;
          m_ptr = g; m_busy = 0;
        end else begin
`ifdef DEMUX_SCHED_TIMEOUT_EN
          m_wait++;
          if (m_wait == TIMEOUT) begin
            x_drop = 1; m_busy = 0;
          end
`endif
        end
      end else if (tb_valid) begin
        m_busy = 1; m_data = tb_data; m_mode = tb_mode; m_dest = tb_dest; m_wait = 0;
        sb_q.push_back(tb_data);
      end
    end
    @(posedge CLK);
    #1;
    if (m_known) begin
      chk("E", E, x_e);
      chk("S", S, x_s);
      chk("I", I, x_i);
      chk("CH_VALID", CH_VALID, x_cv);
      chk("DROP", DROP, x_drop);
      chk("onehot", ($countones(CH_VALID) <= 1), 1);
      chk("cv_iff_e", (CH_VALID != 8'd0), E);
      if (E) chk("cv_at_s", CH_VALID[S], 1);
      if (E || DROP) begin
        if (sb_q.size() == 0) chk("sb_underflow", 0, 1);
        else if (E) chk("sb_order", I, sb_q.pop_front());
        else void'(sb_q.pop_front());
      end
    end
  endtask

  // Offer one word until accepted, then wait for its strobe.
  task automatic send_word(input logic [2:0] d, input logic m, input logic [2:0] dst,
                           input logic [7:0] rdy, output logic [2:0] s_o, output logic [7:0] cv_o);
    bit hs, got;
    s_o = 3'd0; cv_o = 8'd0; got = 0;
    tb_valid = 1; tb_data = d; tb_mode = m; tb_dest = dst; tb_chrdy = rdy;
    for (int n = 0; n < 20; n++) begin
      hs = !m_busy;
      tick();
      if (hs) break;
    end
    tb_valid = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (E) begin
        got = 1; s_o = S; cv_o = CH_VALID;
        break;
      end
    end
    if (!got) chk("send_no_strobe", 0, 1);
  endtask

  initial begin
    logic [2:0] s_o;
    logic [7:0] cv_o;
    int  w, deliveries, drops, drop_at;
    bit  hs;

    // Reset.
    tb_rst = 1;
    tick(); tick();
    tb_rst = 0;
    chk("rst_ready", IN_READY, 1);

    // Eight back-to-back RR words with every sink ready.
    tb_mode = 0; tb_chrdy = 8'hFF; tb_valid = 1; w = 0; tb_data = 0; deliveries = 0;
    for (int n = 0; n < 16; n++) begin
      hs = !m_busy && tb_valid;
      tick();
      if (E) begin
        chk("t1_s", S, deliveries);
        chk("t1_i", I, deliveries);
        deliveries++;
      end
      if (hs) begin
        if (w == 7) tb_valid = 0;
        else begin w++; tb_data = 3'(w); end
      end
    end
    chk("t1_count", deliveries, 8);

    // Move ptr to 2 with a directed word, then RR over channels {2,5}.
    send_word(3'd2, 1'b1, 3'd2, 8'hFF, s_o, cv_o);
    chk("t2_setup_s", s_o, 2);
    send_word(3'b101, 1'b0, 3'd0, 8'b0010_0100, s_o, cv_o);
    chk("t2_s5", s_o, 5);
    chk("t2_cv5", cv_o, 8'h20);
    send_word(3'd1, 1'b0, 3'd0, 8'b0010_0100, s_o, cv_o);
    chk("t2_wrap_s", s_o, 2);
    chk("t2_wrap_cv", cv_o, 8'h04);

    // Directed to channel 6, held off 4 cycles while others are ready.
    tb_valid = 1; tb_data = 3'd4; tb_mode = 1; tb_dest = 3'd6; tb_chrdy = 8'hBF;
    tick();
    tb_valid = 0; tb_mode = 0; tb_dest = 3'd1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("t3_e_low", E, 0);
      chk("t3_rdy_low", IN_READY, 0);
    end
    tb_chrdy = 8'hFF;
    tick();
    chk("t3_e", E, 1);
    chk("t3_s", S, 6);
    chk("t3_cv", CH_VALID, 8'h40);

    // Reset while holding a word in ARB.
    tick();
    tb_valid = 1; tb_data = 3'b011; tb_mode = 0; tb_chrdy = 8'h00;
    tick();
    tb_valid = 0;
    tick();
    tb_rst = 1;
    tick();
    tb_rst = 0;
    chk("t4_e", E, 0);
    chk("t4_cv", CH_VALID, 0);
    chk("t4_drop", DROP, 0);
    chk("t4_rdy", IN_READY, 1);
    send_word(3'd2, 1'b0, 3'd0, 8'hFF, s_o, cv_o);
    chk("t4_ch0", s_o, 0);

    // No sink ready: drop after TIMEOUT ARB cycles, or wait forever.
    tick();
    tb_valid = 1; tb_data = 3'd6; tb_mode = 0; tb_chrdy = 8'h00;
    tick();
    tb_valid = 0; drops = 0; drop_at = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (E) chk("t5_no_strobe", E, 0);
      if (DROP) begin
        drops++; drop_at = n;
        chk("t5_rdy_after", IN_READY, 1);
      end
    end
`ifdef DEMUX_SCHED_TIMEOUT_EN
    chk("t5_drops", drops, 1);
    chk("t5_drop_at", drop_at, TIMEOUT);
`else
    chk("t5_drops", drops, 0);
    chk("t5_still_arb", IN_READY, 0);
`endif
    tb_rst = 1;
    tick();
    tb_rst = 0;

    // Randomized traffic.
    for (int n = 0; n < 10000; n++) begin
      tb_valid = 1'($urandom);
      tb_data  = 3'($urandom);
      tb_mode  = 1'($urandom);
      tb_dest  = 3'($urandom);
      tb_chrdy = 8'($urandom & $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
